// File: rtl/shift_pload_pkg.sv
// Shared encodings and width helpers for the shift/pload blocks.
// Serial-in word assembler and parallel-load shifter both import this.
package shift_pload_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam logic OP_IDLE  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic int beats_f(input int lw, input int iw);
    return lw / iw;
  endfunction

  function automatic int cw_f(input int lw, input int iw);
    return $clog2(lw / iw + 1);
  endfunction

endpackage

// File: rtl/shift_pload_if.sv
// Beat input and word output handshakes of the word assembler.
// slave is the assembler side, master the producer/consumer side.
interface shift_pload_if #(
  parameter int LW = 32,
  parameter int IW = 8
);

  logic [IW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [LW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

endinterface

// File: rtl/shift_pload_timer.sv
// Mid-word idle counter; expire_o flags the last allowed idle cycle.
// Holds at zero while cleared, counts while enabled.
module shift_pload_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/shift_pload.sv
// Serial-in parallel-out word assembler, MS beat first,
// with output backpressure and a mid-word stall timeout.
module shift_pload
  import shift_pload_pkg::*;
#(
  parameter int LOAD_WIDTH = 32,
  parameter int IN_WIDTH   = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  shift_pload_if.slave                            bus,
  output logic                                    busy,
  output logic [cw_f(LOAD_WIDTH, IN_WIDTH)-1:0]   count,
  output logic                                    timeout_err
);

  localparam int BEATS = beats_f(LOAD_WIDTH, IN_WIDTH);
  localparam int CW    = cw_f(LOAD_WIDTH, IN_WIDTH);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [LOAD_WIDTH-1:0] dout_q, dout_d;
  logic                  terr_q;

  logic                  din_ready;
  logic                  accept;
  logic                  consume;
  logic                  complete;
  logic                  fire;
  logic                  expire;
  logic [CW-1:0]         cnt_inc;
  logic [LOAD_WIDTH-1:0] word;

  assign din_ready = !reset && ((state_q != ST_FULL) || bus.dout_ready);
  assign accept    = bus.din_valid && din_ready;
  assign consume   = (state_q == ST_FULL) && bus.dout_ready;
  assign cnt_inc   = count_q + CW'(1);
  assign complete  = accept && (cnt_inc == CW'(BEATS));
  assign fire      = (state_q == ST_FILL) && !accept && expire;

  // Top beat slice is never re-read, so only the lower slices are stored.
  if (BEATS == 1) begin : g_one
    assign word = bus.din;
  end else begin : g_acc
    logic [LOAD_WIDTH-IN_WIDTH-1:0] acc_q;
    assign word = {acc_q, bus.din};
    always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else if (complete || fire) acc_q <= '0;
      else if (accept) acc_q <= word[LOAD_WIDTH-IN_WIDTH-1:0];
    end
  end

  if (TIMEOUT > 0) begin : g_tmr
    logic tmr_clr;
    logic tmr_en;
    assign tmr_clr = accept || (state_q != ST_FILL);
    assign tmr_en  = (state_q == ST_FILL) && !accept;
    shift_pload_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_tmr (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .expire_o (expire)
    );
  end else begin : g_no_tmr
    assign expire = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (accept) begin
      if (complete) begin
        state_d = ST_FULL;
        count_d = '0;
        dout_d  = word;
      end else begin
        state_d = ST_FILL;
        count_d = cnt_inc;
      end
    end else if (consume) begin
      state_d = ST_IDLE;
    end else if (fire) begin
      state_d = ST_IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dout_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      terr_q  <= fire;
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = (state_q == ST_FULL);
  assign busy           = (state_q == ST_FILL);
  assign count          = count_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_shift_pload.sv
// Directed bench for shift_pload: 32/8/16 instance plus a
// 16/8 instance with the timeout disabled.
module tb_shift_pload;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shift_pload_if #(.LW(32), .IW(8)) bus0 ();
  shift_pload_if #(.LW(16), .IW(8)) bus1 ();

  logic       busy0, terr0;
  logic [2:0] cnt0;
  logic       busy1, terr1;
  logic [1:0] cnt1;

  shift_pload #(
    .LOAD_WIDTH (32),
    .IN_WIDTH   (8),
    .TIMEOUT    (16)
  ) u0 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus0),
    .busy        (busy0),
    .count       (cnt0),
    .timeout_err (terr0)
  );

  shift_pload #(
    .LOAD_WIDTH (16),
    .IN_WIDTH   (8),
    .TIMEOUT    (0)
  ) u1 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus1),
    .busy        (busy1),
    .count       (cnt1),
    .timeout_err (terr1)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
  endtask

  task automatic cyc0(input logic dv, input logic [7:0] d,
                      input logic dr);
    @(posedge clk);
    #1;
    bus0.din_valid  = dv;
    bus0.din        = d;
    bus0.dout_ready = dr;
    #1;
  endtask

  task automatic cyc1(input logic dv, input logic [7:0] d,
                      input logic dr);
    @(posedge clk);
    #1;
    bus1.din_valid  = dv;
    bus1.din        = d;
    bus1.dout_ready = dr;
    #1;
  endtask

  task automatic rst_cycle();
    @(posedge clk);
    #1;
    reset          = 1'b1;
    bus0.din_valid = 1'b0;
    bus1.din_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        dv;
    logic [7:0]  din;
    logic        dr;
    logic        rdy;
    logic        vld;
    logic [31:0] dout;
    logic        busy;
    logic [2:0]  cnt;
    logic        terr;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.din = '0; bus0.din_valid = 1'b0; bus0.dout_ready = 1'b1;
    bus1.din = '0; bus1.din_valid = 1'b0; bus1.dout_ready = 1'b1;

    // word with free consumer, then the same word under backpressure
    tbl[0]  = '{1, 8'hDE, 1, 1, 0, 32'h0,        0, 0, 0};
    tbl[1]  = '{1, 8'hAD, 1, 1, 0, 32'h0,        1, 1, 0};
    tbl[2]  = '{1, 8'hBE, 1, 1, 0, 32'h0,        1, 2, 0};
    tbl[3]  = '{1, 8'hEF, 1, 1, 0, 32'h0,        1, 3, 0};
    tbl[4]  = '{0, 8'h00, 1, 1, 1, 32'hDEADBEEF, 0, 0, 0};
    tbl[5]  = '{0, 8'h00, 1, 1, 0, 32'hDEADBEEF, 0, 0, 0};
    tbl[6]  = '{1, 8'hDE, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0};
    tbl[7]  = '{1, 8'hAD, 0, 1, 0, 32'hDEADBEEF, 1, 1, 0};
    tbl[8]  = '{1, 8'hBE, 0, 1, 0, 32'hDEADBEEF, 1, 2, 0};
    tbl[9]  = '{1, 8'hEF, 0, 1, 0, 32'hDEADBEEF, 1, 3, 0};
    tbl[10] = '{1, 8'h11, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0};
    tbl[11] = '{1, 8'h11, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0};
    tbl[12] = '{1, 8'h11, 1, 1, 1, 32'hDEADBEEF, 0, 0, 0};
    tbl[13] = '{0, 8'h00, 1, 1, 0, 32'hDEADBEEF, 1, 1, 0};

    @(posedge clk);
    #2;
    chk("rst din_ready", bus0.din_ready, 0);
    chk("rst dout_valid", bus0.dout_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst dout", bus0.dout, 0);
    chk("rst busy", busy0, 0);
    chk("rst count", cnt0, 0);
    chk("rst terr", terr0, 0);
    chk("rst din_ready off", bus0.din_ready, 1);

    for (int i = 0; i < 14; i++) begin
      cyc0(tbl[i].dv, tbl[i].din, tbl[i].dr);
      chk($sformatf("v%0d rdy", i), bus0.din_ready, tbl[i].rdy);
      chk($sformatf("v%0d vld", i), bus0.dout_valid, tbl[i].vld);
      chk($sformatf("v%0d dout", i), bus0.dout, tbl[i].dout);
      chk($sformatf("v%0d busy", i), busy0, tbl[i].busy);
      chk($sformatf("v%0d cnt", i), cnt0, tbl[i].cnt);
      chk($sformatf("v%0d terr", i), terr0, tbl[i].terr);
    end

    // stall of 16 idle cycles drops the partial word
    rst_cycle();
    cyc0(1, 8'h01, 1);
    cyc0(1, 8'h02, 1);
    for (int i = 0; i < 16; i++) begin
      cyc0(0, 8'h00, 1);
      chk($sformatf("to idle%0d terr", i), terr0, 0);
      chk($sformatf("to idle%0d busy", i), busy0, 1);
    end
    cyc0(0, 8'h00, 1);
    chk("to terr pulse", terr0, 1);
    chk("to count", cnt0, 0);
    chk("to busy", busy0, 0);
    cyc0(1, 8'hA0, 1);
    chk("to terr once", terr0, 0);
    cyc0(1, 8'hA1, 1);
    cyc0(1, 8'hA2, 1);
    cyc0(1, 8'hA3, 1);
    cyc0(0, 8'h00, 1);
    chk("to after vld", bus0.dout_valid, 1);
    chk("to after dout", bus0.dout, 32'hA0A1A2A3);

    // accept on the last allowed idle cycle beats the timeout
    rst_cycle();
    cyc0(1, 8'h01, 1);
    for (int i = 0; i < 15; i++) begin
      cyc0(0, 8'h00, 1);
      chk($sformatf("edge idle%0d terr", i), terr0, 0);
    end
    cyc0(1, 8'h02, 1);
    chk("edge busy", busy0, 1);
    cyc0(1, 8'h03, 1);
    chk("edge terr", terr0, 0);
    chk("edge count", cnt0, 2);
    cyc0(1, 8'h04, 1);
    chk("edge terr2", terr0, 0);
    cyc0(0, 8'h00, 1);
    chk("edge vld", bus0.dout_valid, 1);
    chk("edge dout", bus0.dout, 32'h01020304);

    // reset mid-word
    cyc0(1, 8'h99, 1);
    cyc0(1, 8'hAA, 1);
    cyc0(1, 8'hBB, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus0.din_valid = 1'b1;
    bus0.din = 8'hCC;
    #1;
    chk("mid rst din_ready", bus0.din_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus0.din_valid = 1'b0;
    #1;
    chk("mid rst count", cnt0, 0);
    chk("mid rst busy", busy0, 0);
    chk("mid rst vld", bus0.dout_valid, 0);
    chk("mid rst dout", bus0.dout, 0);
    chk("mid rst terr", terr0, 0);
    cyc0(1, 8'h55, 1);
    cyc0(1, 8'h66, 1);
    chk("mid rst count1", cnt0, 1);
    cyc0(1, 8'h77, 1);
    cyc0(1, 8'h88, 1);
    chk("mid rst terr2", terr0, 0);
    cyc0(0, 8'h00, 1);
    chk("mid rst vld2", bus0.dout_valid, 1);
    chk("mid rst dout2", bus0.dout, 32'h55667788);

    // 16-bit instance, timeout disabled, long stall
    cyc1(1, 8'h12, 1);
    for (int i = 0; i < 100; i++) begin
      cyc1(0, 8'h00, 1);
      if (i % 10 == 0) begin
        chk($sformatf("nt idle%0d busy", i), busy1, 1);
        chk($sformatf("nt idle%0d terr", i), terr1, 0);
      end
    end
    chk("nt count", cnt1, 1);
    cyc1(1, 8'h34, 1);
    chk("nt terr", terr1, 0);
    cyc1(0, 8'h00, 1);
    chk("nt vld", bus1.dout_valid, 1);
    chk("nt dout", bus1.dout, 16'h1234);
    cyc1(0, 8'h00, 1);
    chk("nt vld drop", bus1.dout_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
